// File: rtl/rambus_sample_reader.sv
// rambus_sample_reader: Wishbone read initiator for OpenRAM port B.
// Reads a programmed word window (optionally looping) into a small
// first-word-fall-through FIFO and presents it as a valid/ready sample stream.
module rambus_sample_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        active,
  input  logic        start_i,
  input  logic [7:0]  base_word_i,
  input  logic [7:0]  end_word_i,
  input  logic        loop_i,
  output logic [31:0] sample_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic        rambus_wb_clk_o,
  output logic        rambus_wb_rst_o,
  output logic        rambus_wb_stb_o,
  output logic        rambus_wb_cyc_o,
  output logic        rambus_wb_we_o,
  output logic [3:0]  rambus_wb_sel_o,
  output logic [31:0] rambus_wb_dat_o,
  output logic [9:0]  rambus_wb_adr_o,
  input  logic        rambus_wb_ack_i,
  input  logic [31:0] rambus_wb_dat_i
);

  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  base_q, base_d;
  logic [7:0]  end_q, end_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        loop_q, loop_d;
  logic        stop_q, stop_d;
  logic        stb_q, stb_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [9:0]  adr_q, adr_d;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic push;
  logic pop;
  logic flush;
  logic fifo_empty;

  assign fifo_empty = (cnt_q == '0);
  assign pop        = !fifo_empty && sample_ready_i;

  // Sequencer: window latch, bus request/wait, timeout and abort handling.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    base_d  = base_q;
    end_d   = end_q;
    tmo_d   = tmo_q;
    loop_d  = loop_q;
    stop_d  = stop_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    err_d   = err_q;
    done_d  = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stb_d = 1'b0;
        if (start_i && active) begin
          base_d  = base_word_i;
          end_d   = end_word_i;
          loop_d  = loop_i;
          ptr_d   = base_word_i;
          err_d   = 1'b0;
          stop_d  = 1'b0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (!active) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q < DEPTH_C) begin
          stb_d   = 1'b1;
          adr_d   = {ptr_q, 2'b00};
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // A deactivation during WAIT is remembered so the bus cycle can
        // finish cleanly; its data is then thrown away instead of pushed.
        if (!active) begin
          stop_d = 1'b1;
        end
        if (rambus_wb_ack_i) begin
          stb_d = 1'b0;
          if (stop_q || !active) begin
            flush   = 1'b1;
            state_d = S_IDLE;
          end else begin
            push = 1'b1;
            if (ptr_q == end_q) begin
              if (loop_q) begin
                ptr_d   = base_q;
                state_d = S_REQ;
              end else begin
                done_d  = 1'b1;
                state_d = S_DRAIN;
              end
            end else begin
              ptr_d   = ptr_q + 8'd1;
              state_d = S_REQ;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          flush   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      S_DRAIN: begin
        if (!active) begin
          flush   = 1'b1;
          state_d = S_IDLE;
        end else if (fifo_empty) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer and bus output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      base_q  <= '0;
      end_q   <= '0;
      tmo_q   <= '0;
      loop_q  <= 1'b0;
      stop_q  <= 1'b0;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      base_q  <= base_d;
      end_q   <= end_d;
      tmo_q   <= tmo_d;
      loop_q  <= loop_d;
      stop_q  <= stop_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // FIFO pointer/occupancy next state; flush wins over push and pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        wr_d = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (!push && pop) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // FIFO pointer/occupancy registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage: written only on an accepted acknowledge.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_q] <= rambus_wb_dat_i;
    end
  end

  // Head word is gated so the stream reads zero while the FIFO is empty.
  assign sample_o       = fifo_empty ? '0 : mem_q[rd_q];
  assign sample_valid_o = !fifo_empty;
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign err_o          = err_q;

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = wb_rst_i;
  assign rambus_wb_stb_o = stb_q;
  assign rambus_wb_cyc_o = stb_q;
  assign rambus_wb_we_o  = 1'b0;
  assign rambus_wb_sel_o = 4'hF;
  assign rambus_wb_dat_o = '0;
  assign rambus_wb_adr_o = adr_q;

endmodule
